// File: rtl/dcmac_rx_pkt_filter.sv
// Packet-mode RX FIFO behind the DCMAC segment combiner: buffers each packet until
// its last beat is seen, releases clean packets and discards errored or overflowing ones.
module dcmac_rx_pkt_filter #(
    parameter int SEG_COUNT  = 2,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [128*SEG_COUNT-1:0]  axis_in_tdata,
    input  logic [16*SEG_COUNT-1:0]   axis_in_tkeep,
    input  logic [1:0]                axis_in_tuser,
    input  logic                      axis_in_tlast,
    input  logic                      axis_in_tvalid,
    output logic [128*SEG_COUNT-1:0]  axis_out_tdata,
    output logic [16*SEG_COUNT-1:0]   axis_out_tkeep,
    output logic                      axis_out_tlast,
    output logic                      axis_out_tvalid,
    input  logic                      axis_out_tready,
    output logic [31:0]               cnt_good,
    output logic [31:0]               cnt_err_drop,
    output logic [31:0]               cnt_ovf_drop,
    output logic                      dbg_discard
);

    localparam int DW = 128 * SEG_COUNT;
    localparam int KW = 16 * SEG_COUNT;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int MW = DW + KW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    typedef enum logic {
        ACCEPT  = 1'b0,
        DISCARD = 1'b1
    } wr_state_t;

    wr_state_t         wr_state;
    logic              bad;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     commit_ptr;
    logic [PW-1:0]     commit_vis;
    logic [PW-1:0]     rd_ptr;
    logic [MW-1:0]     mem [FIFO_DEPTH];
    logic              full;
    logic              pkt_bad;
    logic              mem_we;
    logic              load;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign full        = (wr_ptr - rd_ptr) == DEPTH_P;
    assign pkt_bad     = bad | (|axis_in_tuser);
    assign mem_we      = axis_in_tvalid && (wr_state == ACCEPT) && !full;
    assign dbg_discard = (wr_state == DISCARD);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr[AW-1:0]] <= {axis_in_tdata, axis_in_tkeep, axis_in_tlast};
        end
    end

    // Write side: wr_ptr runs ahead speculatively; commit_ptr only moves on a clean
    // last beat, and any drop rewinds wr_ptr to commit_ptr at the deciding edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state     <= ACCEPT;
            bad          <= 1'b0;
            wr_ptr       <= '0;
            commit_ptr   <= '0;
            cnt_good     <= '0;
            cnt_err_drop <= '0;
            cnt_ovf_drop <= '0;
        end else if (axis_in_tvalid) begin
            case (wr_state)
                ACCEPT: begin
                    if (!full) begin
                        if (axis_in_tlast) begin
                            bad <= 1'b0;
                            if (pkt_bad) begin
                                wr_ptr       <= commit_ptr;
                                cnt_err_drop <= sat_inc(cnt_err_drop);
                            end else begin
                                wr_ptr     <= wr_ptr + ONE_P;
                                commit_ptr <= wr_ptr + ONE_P;
                                cnt_good   <= sat_inc(cnt_good);
                            end
                        end else begin
                            bad    <= pkt_bad;
                            wr_ptr <= wr_ptr + ONE_P;
                        end
                    end else begin
                        // Overflow outranks any error already seen on this packet.
                        wr_ptr       <= commit_ptr;
                        cnt_ovf_drop <= sat_inc(cnt_ovf_drop);
                        bad          <= 1'b0;
                        if (!axis_in_tlast) begin
                            wr_state <= DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (axis_in_tlast) begin
                        wr_state <= ACCEPT;
                        bad      <= 1'b0;
                    end
                end
                default: wr_state <= ACCEPT;
            endcase
        end
    end

    // Output handshake: a beat transfers on a cycle where tvalid and tready are both
    // high; once tvalid rises, it and tdata/tkeep/tlast hold until that transfer.
    // commit_vis is a registered copy of commit_ptr, so a commit is seen one cycle later.
    assign load = (!axis_out_tvalid || axis_out_tready) && (rd_ptr != commit_vis);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr          <= '0;
            commit_vis      <= '0;
            axis_out_tvalid <= 1'b0;
            axis_out_tdata  <= '0;
            axis_out_tkeep  <= '0;
            axis_out_tlast  <= 1'b0;
        end else begin
            commit_vis <= commit_ptr;
            if (load) begin
                {axis_out_tdata, axis_out_tkeep, axis_out_tlast} <= mem[rd_ptr[AW-1:0]];
                rd_ptr          <= rd_ptr + ONE_P;
                axis_out_tvalid <= 1'b1;
            end else if (axis_out_tready) begin
                axis_out_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dcmac_rx_pkt_filter.sv
// Directed and randomized checks of dcmac_rx_pkt_filter against a packet-level
// model: good packets go to an expected beat queue, dropped ones only bump counters.
module tb_dcmac_rx_pkt_filter;

    localparam int SEG_COUNT  = 2;
    localparam int FIFO_DEPTH = 16;
    localparam int DW = 128 * SEG_COUNT;
    localparam int KW = 16 * SEG_COUNT;
    localparam int W  = DW + KW + 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic [DW-1:0] axis_in_tdata;
    logic [KW-1:0] axis_in_tkeep;
    logic [1:0]    axis_in_tuser;
    logic          axis_in_tlast;
    logic          axis_in_tvalid;
    logic [DW-1:0] axis_out_tdata;
    logic [KW-1:0] axis_out_tkeep;
    logic          axis_out_tlast;
    logic          axis_out_tvalid;
    logic          axis_out_tready;
    logic [31:0]   cnt_good;
    logic [31:0]   cnt_err_drop;
    logic [31:0]   cnt_ovf_drop;
    logic          dbg_discard;

    always #5 clk = ~clk;

    dcmac_rx_pkt_filter #(
        .SEG_COUNT  (SEG_COUNT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .axis_in_tdata   (axis_in_tdata),
        .axis_in_tkeep   (axis_in_tkeep),
        .axis_in_tuser   (axis_in_tuser),
        .axis_in_tlast   (axis_in_tlast),
        .axis_in_tvalid  (axis_in_tvalid),
        .axis_out_tdata  (axis_out_tdata),
        .axis_out_tkeep  (axis_out_tkeep),
        .axis_out_tlast  (axis_out_tlast),
        .axis_out_tvalid (axis_out_tvalid),
        .axis_out_tready (axis_out_tready),
        .cnt_good        (cnt_good),
        .cnt_err_drop    (cnt_err_drop),
        .cnt_ovf_drop    (cnt_ovf_drop),
        .dbg_discard     (dbg_discard)
    );

    int         checks = 0;
    int         failures = 0;
    logic [W-1:0] exp_q[$];
    int         exp_good = 0;
    int         exp_err = 0;
    int         exp_ovf = 0;
    int         rdy_mode = 0;   // 0 hold, 1 random, 2 toggle
    bit         prev_stall = 0;
    logic [W-1:0] prev_beat = '0;
    bit         track = 0;
    bit         seen = 0;
    int         gaps = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] out_beat();
        return {axis_out_tdata, axis_out_tkeep, axis_out_tlast};
    endfunction

    function automatic logic [W-1:0] rand_beat(input bit last);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return {d, KW'($urandom), last};
    endfunction

    // Sampled at the negedge: a tvalid&tready seen here transfers at the next posedge.
    task automatic monitor();
        if (!resetn) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 512'(axis_out_tvalid), 512'(1'b1));
                chk("stall_hold", 512'(out_beat()), 512'(prev_beat));
            end
            if (axis_out_tvalid && axis_out_tready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", 512'(axis_out_tvalid), 512'(1'b0));
                else chk("out_beat", 512'(out_beat()), 512'(exp_q.pop_front()));
            end
            if (track) begin
                if (axis_out_tvalid) seen = 1;
                else if (seen && exp_q.size() != 0) gaps++;
            end
            prev_stall = axis_out_tvalid && !axis_out_tready;
            prev_beat  = out_beat();
        end
    endtask

    task automatic tick();
        case (rdy_mode)
            1: axis_out_tready = 1'($urandom_range(0, 1));
            2: axis_out_tready = ~axis_out_tready;
            default: ;
        endcase
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [W-1:0] b, input logic [1:0] user);
        {axis_in_tdata, axis_in_tkeep, axis_in_tlast} = b;
        axis_in_tuser  = user;
        axis_in_tvalid = 1'b1;
        tick();
        axis_in_tvalid = 1'b0;
        axis_in_tuser  = 2'b00;
        axis_in_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input int len, input int err_beat, input logic [1:0] err_val,
                            input bit ovf, input bit gaps_en);
        logic [W-1:0] beats[$];
        logic [W-1:0] b;
        for (int i = 0; i < len; i++) begin
            b = rand_beat(i == len - 1);
            beats.push_back(b);
            drive_beat(b, (i == err_beat) ? err_val : 2'b00);
            if (gaps_en && i != len - 1) repeat ($urandom_range(0, 2)) tick();
        end
        if (ovf) exp_ovf++;
        else if (err_beat >= 0 && err_val != 2'b00) exp_err++;
        else begin
            exp_good++;
            foreach (beats[i]) exp_q.push_back(beats[i]);
        end
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_left", 512'(exp_q.size()), 512'(0));
        tick();
        tick();
        chk("idle_tvalid", 512'(axis_out_tvalid), 512'(1'b0));
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_good"}, 512'(cnt_good), 512'(exp_good));
        chk({tag, "_err"}, 512'(cnt_err_drop), 512'(exp_err));
        chk({tag, "_ovf"}, 512'(cnt_ovf_drop), 512'(exp_ovf));
    endtask

    initial begin
        int n;
        int len;
        int eb;
        resetn          = 1'b0;
        axis_in_tdata   = '0;
        axis_in_tkeep   = '0;
        axis_in_tuser   = 2'b00;
        axis_in_tlast   = 1'b0;
        axis_in_tvalid  = 1'b0;
        axis_out_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_tvalid", 512'(axis_out_tvalid), 512'(1'b0));
        chk("rst_tdata", 512'(axis_out_tdata), 512'(0));
        chk("rst_tkeep", 512'(axis_out_tkeep), 512'(0));
        chk("rst_tlast", 512'(axis_out_tlast), 512'(1'b0));
        check_counters("rst");
        resetn = 1'b1;
        tick();

        // Single good packet and commit-to-output latency
        axis_out_tready = 1'b1;
        send_pkt(3, -1, 2'b00, 0, 0);
        chk("lat_e0", 512'(axis_out_tvalid), 512'(1'b0));
        tick();
        chk("lat_e1", 512'(axis_out_tvalid), 512'(1'b0));
        tick();
        chk("lat_e2", 512'(axis_out_tvalid), 512'(1'b1));
        wait_drain(50);
        check_counters("single");

        // Error on beat 2 of 4, then a clean 2-beat packet
        send_pkt(4, 1, 2'b01, 0, 0);
        send_pkt(2, -1, 2'b00, 0, 0);
        wait_drain(50);
        check_counters("err");

        // Overflow with the sink stalled: 9 beats in memory plus 1 in the output
        // register leave 7 free entries, so a second 10-beat packet cannot fit
        axis_out_tready = 1'b0;
        tick();
        send_pkt(10, -1, 2'b00, 0, 0);
        send_pkt(10, 1, 2'b10, 1, 0);
        check_counters("ovf");
        chk("ovf_state", 512'(dbg_discard), 512'(1'b0));
        chk("ovf_held", 512'(axis_out_tvalid), 512'(1'b1));
        axis_out_tready = 1'b1;
        wait_drain(100);
        check_counters("ovf_drain");

        // Back-pressure toggling every cycle
        rdy_mode = 2;
        send_pkt(6, -1, 2'b00, 0, 0);
        wait_drain(100);
        rdy_mode = 0;
        axis_out_tready = 1'b1;
        check_counters("bp");

        // 100 back-to-back single-beat packets
        track = 1;
        seen  = 0;
        gaps  = 0;
        for (int i = 0; i < 100; i++) send_pkt(1, -1, 2'b00, 0, 0);
        wait_drain(50);
        track = 0;
        chk("b2b_gaps", 512'(gaps), 512'(0));
        check_counters("b2b");

        // Reset during beat 3 of 5 while a committed packet streams out
        send_pkt(8, -1, 2'b00, 0, 0);
        drive_beat(rand_beat(1'b0), 2'b00);
        drive_beat(rand_beat(1'b0), 2'b00);
        {axis_in_tdata, axis_in_tkeep, axis_in_tlast} = rand_beat(1'b0);
        axis_in_tvalid = 1'b1;
        #2;
        resetn         = 1'b0;
        axis_in_tvalid = 1'b0;
        exp_q.delete();
        exp_good = 0;
        exp_err  = 0;
        exp_ovf  = 0;
        #1;
        chk("mrst_tvalid", 512'(axis_out_tvalid), 512'(1'b0));
        chk("mrst_tdata", 512'(axis_out_tdata), 512'(0));
        check_counters("mrst");
        tick();
        tick();
        resetn = 1'b1;
        tick();
        send_pkt(5, -1, 2'b00, 0, 0);
        wait_drain(50);
        check_counters("post_rst");

        // Randomized traffic: random lengths, errors, gaps and tready
        rdy_mode = 1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 8);
            eb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            n   = 0;
            while (exp_q.size() + len > FIFO_DEPTH - 2 && n < 500) begin
                tick();
                n++;
            end
            if (n >= 500) chk("guard_wait", 512'(exp_q.size()), 512'(0));
            send_pkt(len, eb, 2'($urandom_range(1, 3)), 0, 1);
        end
        rdy_mode = 0;
        axis_out_tready = 1'b1;
        wait_drain(500);
        check_counters("rand");
        chk("rand_state", 512'(dbg_discard), 512'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcmac_rx_pkt_filter.md
# dcmac_rx_pkt_filter

Packet-mode receive FIFO that sits directly downstream of the DCMAC segment combiner. It consumes the combiner's unified, unthrottled AXI stream and holds each packet until its last beat has been checked. Clean packets are released on a back-pressurable AXI stream. Packets flagged with any tuser error, or that overflow the buffer, are discarded in their entirety.

## Interface
Parameters:
- SEG_COUNT, 2, number of 128-bit segments per beat (2 or 4); data width is 128*SEG_COUNT.
- FIFO_DEPTH, 512, buffer depth in beats; power of two, minimum 16.

Ports:
- clk  in  1  sole clock.
- resetn  in  1  asynchronous active-low reset.
- axis_in_tdata  in  128*SEG_COUNT  input beat data.
- axis_in_tkeep  in  16*SEG_COUNT  input byte enables.
- axis_in_tuser  in  2  error flags; nonzero on any beat marks the packet bad.
- axis_in_tlast  in  1  last beat of packet.
- axis_in_tvalid  in  1  beat valid. There is no tready; every valid beat is consumed.
- axis_out_tdata  out  128*SEG_COUNT  output data.
- axis_out_tkeep  out  16*SEG_COUNT  output byte enables.
- axis_out_tlast  out  1  last beat of packet.
- axis_out_tvalid  out  1  output valid.
- axis_out_tready  in  1  downstream ready.
- cnt_good  out  32  packets committed; saturating.
- cnt_err_drop  out  32  packets dropped for a tuser error; saturating.
- cnt_ovf_drop  out  32  packets dropped for overflow; saturating.

## Operation
- Storage is a memory of FIFO_DEPTH entries of {tdata, tkeep, tlast}, plus three pointers of width log2(FIFO_DEPTH)+1: wr_ptr (speculative), commit_ptr and rd_ptr.
- full: wr_ptr - rd_ptr == FIFO_DEPTH.
- Read-side empty: rd_ptr == commit_ptr. The reader never sees uncommitted beats.
- Write FSM has two states, ACCEPT and DISCARD. It also keeps a sticky flag `bad` that ORs together the tuser bits of the current packet.
- ACCEPT, valid beat, not full:
  - Write the beat; wr_ptr+1.
  - If the beat is tlast and (bad | |tuser) is 0: commit_ptr <= wr_ptr+1 and cnt_good+1.
  - If the beat is tlast and the packet is bad: wr_ptr <= commit_ptr (rollback) and cnt_err_drop+1.
  - On any tlast beat, clear bad.
- ACCEPT, valid beat, full:
  - wr_ptr <= commit_ptr and cnt_ovf_drop+1.
  - If the beat is not tlast, go to DISCARD. If it is tlast, stay in ACCEPT and clear bad.
- DISCARD: drop every beat. On the tlast beat, go to ACCEPT and clear bad. Counters do not change in DISCARD.
- Overflow takes priority over error: a packet that both overflows and carries an error counts only in cnt_ovf_drop.
- A packet longer than FIFO_DEPTH beats always overflows and is dropped.
- Read side:
  - A one-entry output register forms a first-word-fall-through stage.
  - The register loads from memory whenever it is empty, or being emptied (tvalid & tready), and rd_ptr != commit_ptr.
  - tvalid and tdata are stable while tvalid=1 and tready=0.
- Reads and writes in the same cycle are independent.
- A commit and a read in the same cycle are allowed. The reader uses the registered commit_ptr, so newly committed data becomes visible one cycle later.
- Counters saturate at 0xFFFF_FFFF.
- Upstream guarantees the input is idle (between packets) when resetn deasserts. The FSM leaves reset in ACCEPT.

## Timing
- Reset (asynchronous assert, synchronous release):
  - Pointers 0; FSM in ACCEPT; bad=0; output register empty.
  - axis_out_tvalid=0; tdata, tkeep and tlast read as 0.
  - All counters 0.
  - Any partially received or buffered packet is lost.
- Latency: FIFO empty and tready=1, with the tlast beat of a good packet sampled at edge E0. Then axis_out_tvalid=1 with the packet's first beat after edge E0+2.
- Throughput: one beat per clock in and out once a packet is committed; a multi-beat packet streams with no bubbles while tready=1.
- Rollback takes effect at the same edge that samples the offending beat. A new packet may start on the very next cycle.
- Counter outputs are registered and update at the edge that samples the deciding beat.

## Test plan
- Single good packet: 3 beats, tuser=0, tready=1 -> 3 beats out unchanged, tvalid rises 2 edges after tlast, cnt_good=1.
- Error mid-packet: 4-beat packet with tuser=2'b01 on beat 2 only, then a good 2-beat packet -> only the 2-beat packet appears, cnt_err_drop=1, cnt_good=1, and the FIFO is empty afterward (rd_ptr==wr_ptr).
- Overflow: FIFO_DEPTH=16, tready=0, a good 10-beat packet followed by a 10-beat packet -> the second packet is dropped and cnt_ovf_drop=1. After raising tready, exactly the first 10 beats emerge.
- Back-pressure: tready toggling 1/0 every cycle over a 6-beat packet -> all 6 beats delivered in order, with no tdata change while tvalid=1 and tready=0.
- Back-to-back traffic: 100 consecutive 1-beat good packets with tvalid held high and tready=1 -> 100 beats out with no gaps after the first, cnt_good=100.
- Reset mid-packet: assert resetn=0 during beat 3 of 5 while a committed packet is being read -> after reset axis_out_tvalid=0 and all counters 0. The next clean packet after input idle passes normally.
